// File: rtl/mul_pipe_pkg.sv
// Shared widths, Booth digit encoding and tree-sizing helpers for mul_pipe.
package mul_pipe_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int TAG_W_DEF = 5;

  typedef struct packed {
    logic neg;
    logic two;
    logic one;
  } booth_t;

  localparam booth_t BOOTH_ZERO = 3'b000;
  localparam booth_t BOOTH_ONE  = 3'b001;
  localparam booth_t BOOTH_TWO  = 3'b010;
  localparam booth_t BOOTH_NEG  = 3'b100;

  // Radix-4 digit from the overlapping triplet {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_t booth_enc(input logic [2:0] trip);
    booth_t d;
    case (trip)
      3'b001, 3'b010: d = BOOTH_ONE;
      3'b011:         d = BOOTH_TWO;
      3'b100:         d = BOOTH_NEG | BOOTH_TWO;
      3'b101, 3'b110: d = BOOTH_NEG | BOOTH_ONE;
      default:        d = BOOTH_ZERO;
    endcase
    return d;
  endfunction

  function automatic int num_pp(input int w);
    return w / 2 + 1;
  endfunction

  // Each 3:2 compressor removes one row; stop when two rows remain.
  function automatic int csa_count(input int w);
    return num_pp(w) - 2;
  endfunction

endpackage

// File: rtl/mul_csa32.sv
// Generic 3:2 carry-save compressor; combinational, carry row pre-shifted left by one.
module mul_csa32 #(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = ((a_i & b_i) | (a_i & c_i) | (b_i & c_i)) << 1;

endmodule

// File: rtl/mul_pipe.sv
// 3-stage radix-4 Booth / CSA-tree multiplier, accept in N -> out_valid in N+3, 1 op/cycle.
// Stages advance only into empty or draining stages; flush kills all in-flight ops.
module mul_pipe
  import mul_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic               mul_clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW   = 2 * WIDTH;
  localparam int NPP  = num_pp(WIDTH);
  localparam int NCSA = csa_count(WIDTH);

  logic live_q;
  logic s1_vld_q, s1_vld_d;
  logic s2_vld_q, s2_vld_d;
  logic out_vld_q, out_vld_d;
  logic en1, en2, en3, accept;

  logic [PW-1:0]    pp_d [NPP];
  logic [PW-1:0]    pp_q [NPP];
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q, out_tag_q;
  logic [PW-1:0]    sum_d, carry_d, s2_sum_q, s2_carry_q, out_result_q;

  // Load enables chain backwards from the output so a full pipe stalls without bubbles.
  assign en3      = ~out_vld_q | out_ready;
  assign en2      = ~s2_vld_q | en3;
  assign en1      = ~s1_vld_q | en2;
  assign in_ready = live_q & en1 & ~flush;
  assign accept   = in_valid & in_ready;

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s2_vld_d  = s2_vld_q;
    out_vld_d = out_vld_q;
    if (flush) begin
      s1_vld_d  = 1'b0;
      s2_vld_d  = 1'b0;
      out_vld_d = 1'b0;
    end else begin
      if (en1) s1_vld_d = accept;
      if (en2) s2_vld_d = s1_vld_q;
      if (en3) out_vld_d = s2_vld_q;
    end
  end

  logic             a_ext, b_ext;
  logic [PW-1:0]    a_pos, a_neg, a2_pos, a2_neg;
  logic [WIDTH+2:0] b_x;

  assign a_ext  = in_signed & in_a[WIDTH-1];
  assign b_ext  = in_signed & in_b[WIDTH-1];
  assign a_pos  = {{WIDTH{a_ext}}, in_a};
  assign a_neg  = -a_pos;
  assign a2_pos = a_pos << 1;
  assign a2_neg = -a2_pos;
  // Two extension bits on top, implicit zero below bit 0 for the first triplet.
  assign b_x    = {b_ext, b_ext, in_b, 1'b0};

  booth_t        dig;
  logic [PW-1:0] sel;

  always_comb begin
    dig = BOOTH_ZERO;
    sel = '0;
    for (int i = 0; i < NPP; i++) begin
      dig = booth_enc(b_x[2*i +: 3]);
      sel = '0;
      if (dig.two)      sel = dig.neg ? a2_neg : a2_pos;
      else if (dig.one) sel = dig.neg ? a_neg : a_pos;
      pp_d[i] = sel << (2 * i);
    end
  end

  // Rows are consumed in FIFO order, so node n is a partial product (n < NPP)
  // or an output of compressor (n-NPP)/2; the last compressor yields the final pair.
  for (genvar k = 0; k < NCSA; k++) begin : g_csa
    logic [PW-1:0] op [3];
    logic [PW-1:0] sum, carry;
    for (genvar j = 0; j < 3; j++) begin : g_op
      localparam int N = 3 * k + j;
      if (N < NPP) begin : g_leaf
        assign op[j] = pp_q[N];
      end else if ((N - NPP) % 2 == 0) begin : g_s
        assign op[j] = g_csa[(N - NPP) / 2].sum;
      end else begin : g_c
        assign op[j] = g_csa[(N - NPP) / 2].carry;
      end
    end
    mul_csa32 #(.W(PW)) u_csa (
      .a_i     (op[0]),
      .b_i     (op[1]),
      .c_i     (op[2]),
      .sum_o   (sum),
      .carry_o (carry)
    );
  end

  assign sum_d   = g_csa[NCSA-1].sum;
  assign carry_d = g_csa[NCSA-1].carry;

  always_ff @(posedge mul_clk) begin
    if (accept) begin
      pp_q     <= pp_d;
      s1_tag_q <= in_tag;
    end
    if (en2 & s1_vld_q) begin
      s2_sum_q   <= sum_d;
      s2_carry_q <= carry_d;
      s2_tag_q   <= s1_tag_q;
    end
  end

  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      live_q       <= 1'b0;
      s1_vld_q     <= 1'b0;
      s2_vld_q     <= 1'b0;
      out_vld_q    <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      live_q    <= 1'b1;
      s1_vld_q  <= s1_vld_d;
      s2_vld_q  <= s2_vld_d;
      out_vld_q <= out_vld_d;
      if (en3 & s2_vld_q) begin
        out_result_q <= s2_sum_q + s2_carry_q;
        out_tag_q    <= s2_tag_q;
      end
    end
  end

  assign out_valid  = out_vld_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_mul_pipe.sv
// Bench for mul_pipe: constant vector table, directed stall/flush/reset sequences,
// and random traffic against an in-order queue model of the multiplier.
module tb_mul_pipe;
  localparam int W = 32;
  localparam int T = 5;

  logic           mul_clk = 1'b0;
  logic           resetn = 1'b0;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_signed = 1'b0;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic [T-1:0]   in_tag = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] out_result;
  logic [T-1:0]   out_tag;

  always #5 mul_clk = ~mul_clk;

  mul_pipe #(.WIDTH(W), .TAG_W(T)) dut (
    .mul_clk    (mul_clk),
    .resetn     (resetn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_signed  (in_signed),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  typedef struct packed {
    logic [2*W-1:0] res;
    logic [T-1:0]   tag;
  } exp_t;

  typedef struct {
    bit             s;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [T-1:0]   tag;
    logic [2*W-1:0] exp;
  } vec_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_acc = 0;
  int   n_out = 0;
  bit   live = 1'b0;

  // in_ready may only rise once a clock edge has seen resetn high.
  always @(posedge mul_clk or negedge resetn) live <= resetn;

  function automatic logic [2*W-1:0] model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] xa, xb;
    if (s) begin
      xa = $signed(a);
      xb = $signed(b);
      return xa * xb;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Called on the falling edge: judges the handshakes that the next rising edge will commit.
  task automatic sb_eval();
    if (!resetn) begin
      q.delete();
      return;
    end
    chk("in_ready_rule", in_ready, live && !flush && (q.size() < 3 || out_ready));
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", out_valid, 0);
      end else begin
        chk("result", out_result, q[0].res);
        chk("tag", out_tag, q[0].tag);
        if (out_ready) begin
          void'(q.pop_front());
          n_out++;
        end
      end
    end
    if (flush) q.delete();
    else if (in_valid && in_ready) begin
      q.push_back('{res: model(in_signed, in_a, in_b), tag: in_tag});
      n_acc++;
    end
  endtask

  task automatic step();
    @(negedge mul_clk);
    sb_eval();
  endtask

  task automatic nxt();
    @(posedge mul_clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  vec_t vt[11];

  initial begin
    int base, obase;
    vt[0]  = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  64'hFFFF_FFFE_0000_0001};
    vt[1]  = '{1, 32'h8000_0000, 32'h8000_0000, 5'd1,  64'h4000_0000_0000_0000};
    vt[2]  = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 5'd2,  64'hFFFF_FFFF_FFFF_FFFF};
    vt[3]  = '{0, 32'd3,         32'd5,         5'd3,  64'd15};
    vt[4]  = '{1, 32'hFFFF_FFFD, 32'd7,         5'd4,  64'hFFFF_FFFF_FFFF_FFEB};
    vt[5]  = '{0, 32'h8000_0000, 32'd2,         5'd5,  64'h0000_0001_0000_0000};
    vt[6]  = '{1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd6,  64'h3FFF_FFFF_0000_0001};
    vt[7]  = '{1, 32'h8000_0000, 32'h7FFF_FFFF, 5'd8,  64'hC000_0000_8000_0000};
    vt[8]  = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 64'h0000_0000_0000_0001};
    vt[9]  = '{0, 32'hFFFF_FFFF, 32'd2,         5'd16, 64'h0000_0001_FFFF_FFFE};
    vt[10] = '{0, 32'h8000_0000, 32'h8000_0000, 5'd0,  64'h4000_0000_0000_0000};

    step();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_result", out_result, 0);
    chk("reset_out_tag", out_tag, 0);
    chk("reset_in_ready", in_ready, 0);
    nxt();
    resetn = 1'b1;
    step();
    nxt();

    // Isolated ops: value, tag and three-cycle latency.
    foreach (vt[i]) begin
      in_valid = 1'b1; in_signed = vt[i].s; in_a = vt[i].a; in_b = vt[i].b;
      in_tag = vt[i].tag; out_ready = 1'b1;
      step();
      chk("vec_accept", in_ready, 1);
      nxt();
      in_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        step();
        chk("vec_latency", out_valid, c == 3);
        if (c == 3) begin
          chk("vec_result", out_result, vt[i].exp);
          chk("vec_tag", out_tag, vt[i].tag);
        end
        nxt();
      end
    end

    // Back-pressure: six ops offered back to back with the consumer stalled.
    base = n_acc; obase = n_out;
    out_ready = 1'b0; in_signed = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_a = 32'(n_acc - base + 1); in_b = 32'(n_acc - base + 100);
      in_tag = 5'(n_acc - base);
      step();
      nxt();
    end
    chk("bp_accepted", n_acc - base, 3);
    chk("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && (n_out - obase) < 6; c++) begin
      in_valid = (n_acc - base) < 6;
      in_a = 32'(n_acc - base + 1); in_b = 32'(n_acc - base + 100); in_tag = 5'(n_acc - base);
      step();
      nxt();
    end
    in_valid = 1'b0;
    chk("bp_accepted_total", n_acc - base, 6);
    chk("bp_delivered", n_out - obase, 6);
    chk("bp_queue_empty", q.size(), 0);

    // Flush with two ops in flight and a third presented in the flush cycle.
    in_valid = 1'b1; in_a = 32'd11; in_b = 32'd13; in_tag = 5'd1;
    step(); nxt();
    in_a = 32'd17; in_tag = 5'd2;
    step(); nxt();
    in_a = 32'd19; in_tag = 5'd3; flush = 1'b1;
    step();
    chk("flush_in_ready", in_ready, 0);
    nxt();
    flush = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("flush_no_out", out_valid, 0);
      nxt();
    end
    in_valid = 1'b1; in_a = 32'd3; in_b = 32'd5; in_tag = 5'd9;
    step();
    chk("post_flush_accept", in_ready, 1);
    nxt();
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      chk("post_flush_latency", out_valid, c == 3);
      if (c == 3) begin
        chk("post_flush_result", out_result, 64'd15);
        chk("post_flush_tag", out_tag, 5'd9);
      end
      nxt();
    end

    // Asynchronous reset while a result is waiting on the output.
    out_ready = 1'b0; in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678; in_tag = 5'd21;
    for (int c = 0; c < 4; c++) begin
      step(); nxt();
    end
    in_valid = 1'b0;
    step();
    chk("rst_pre_valid", out_valid, 1);
    nxt();
    resetn = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_result", out_result, 0);
    chk("rst_async_tag", out_tag, 0);
    chk("rst_async_in_ready", in_ready, 0);
    step(); nxt();
    step(); nxt();
    resetn = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("rst_no_result", out_valid, 0);
      nxt();
    end

    // Random traffic against the queue model.
    base = n_acc;
    for (int c = 0; c < 40000 && (n_acc - base) < 10000; c++) begin
      in_valid  = $urandom_range(0, 9) < 7;
      in_signed = 1'($urandom);
      in_a      = rnd_op();
      in_b      = rnd_op();
      in_tag    = 5'($urandom);
      out_ready = $urandom_range(0, 9) < 7;
      flush     = $urandom_range(0, 49) == 0;
      step();
      nxt();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(); nxt();
    end
    chk("rand_op_count", (n_acc - base) >= 10000, 1);
    chk("drain_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
